// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_adder_pkg;

  // Default operand/result width
  localparam int DEFAULT_WIDTH = 4;

  // Controller states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit counter width: enough to hold the value WIDTH
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// One-bit full adder shared by every bit position of the serial adder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB-first over WIDTH bits (SERIAL_ADDER_SUB_EN adds a subtract port).
// Latency: accept edge E, done pulse and new f/cout in the cycle after edge E+WIDTH; one op per WIDTH+1 cycles.
// Backpressure: start is only accepted in IDLE or DONE; start during RUN is dropped, not queued.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST_CNT = cnt_t'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  cnt_t             cnt_q, cnt_d;

  logic             accept;
  logic             last_bit;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic [WIDTH-1:0] res_next;

  // Subtraction is a + ~b + 1, so only the B operand and initial carry differ
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_bit = (state_q == ST_RUN) && (cnt_q == LAST_CNT);
  assign res_next = {fa_s, res_sh_q[WIDTH-1:1]};

  fa_cell u_fa_cell (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE can re-accept immediately for back-to-back operation
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next values: load on accept, shift one bit per RUN cycle, publish result on the last bit
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    f_d      = f_q;
    cout_d   = cout_q;
    if (accept) begin
      a_sh_d   = a;
      b_sh_d   = b_load;
      carry_d  = carry_load;
      res_sh_d = '0;
      cnt_d    = '0;
    end else if (state_q == ST_RUN) begin
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      carry_d  = fa_co;
      res_sh_d = res_next;
      cnt_d    = cnt_q + cnt_t'(1);
      if (last_bit) begin
        f_d    = res_next;
        cout_d = fa_co;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      f_q      <= '0;
      cout_q   <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      f_q      <= f_d;
      cout_q   <= cout_d;
    end
  end

  assign f    = f_q;
  assign cout = cout_q;

endmodule
